// File: rtl/uart_tx_if.sv
// uart_tx_if: byte request and serial line status between a transmit client and uart_tx.
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;
    modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, input TX_OUT, Busy);
    modport slave  (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per request as start, data LSB first, optional parity, stop.
module uart_tx #(parameter int DATA_WIDTH = 8) (
    input logic     CLK,
    input logic     RST,
    uart_tx_if.slave bus
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  tx_q, tx_d, busy_q, busy_d;
    logic                  accept, last, par_bit;
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        accept    = bus.DATA_VALID && (state_q == IDLE || state_q == STOP);
        last      = bit_cnt_q == CW'(DATA_WIDTH - 1);
        par_bit   = ^data_q ^ par_typ_q;
        case (state_q)
            IDLE, STOP: state_d = accept ? START : IDLE;
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                state_d   = last ? (par_en_q ? PARITY : STOP) : DATA;
                bit_cnt_d = last ? bit_cnt_q : CW'(bit_cnt_q + 1'b1);
            end
            PARITY: state_d = STOP;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            data_d    = bus.P_DATA;
            par_en_d  = bus.PAR_EN;
            par_typ_d = bus.PAR_TYP;
        end
        // Outputs are registered, so they are decoded from the state being entered.
        tx_d   = state_d == START  ? 1'b0 :
                 state_d == DATA   ? data_q[bit_cnt_d] :
                 state_d == PARITY ? par_bit : 1'b1;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end
    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;
endmodule
